// File: rtl/cpu_pkg.sv
// Shared CPU pipeline types: register index width and the operand bypass select encoding.
package cpu_pkg;

   localparam int REG_ADDR_W = 5;

   typedef enum logic [1:0] {
      BYP_RF  = 2'b00,
      BYP_MEM = 2'b01,
      BYP_WB  = 2'b10,
      BYP_PWB = 2'b11
   } bypass_sel_t;

endpackage

// File: rtl/cpu_fw_if.sv
// Signal bundle between the execute, memory and writeback stages and the forwarding unit.
interface CPU_FWUnit_if #(
   parameter int AW = 5
);
   import cpu_pkg::*;

   logic [AW-1:0] ra_id;
   logic [AW-1:0] rb_id;
   bypass_sel_t   ra_bypass;
   bypass_sel_t   rb_bypass;
   logic [AW-1:0] rd_mem;
   logic          writeback_mem;
   logic [AW-1:0] rd_wb;
   logic          writeback_wb;

   modport master_execute   (output ra_id, rb_id, input ra_bypass, rb_bypass);
   modport master_memory    (output rd_mem, writeback_mem);
   modport master_writeback (output rd_wb, writeback_wb);

endinterface

// File: rtl/cpu_fw_operand_sel.sv
// Combinational priority compare for one execute-stage operand: youngest matching producer wins.
module cpu_fw_operand_sel #(
   parameter int REG_ADDR_W  = 5,
   parameter bit ZERO_REG_EN = 1'b1
) (
   input  logic [REG_ADDR_W-1:0] rx_id,
   input  logic [REG_ADDR_W-1:0] rd_mem,
   input  logic                  writeback_mem,
   input  logic [REG_ADDR_W-1:0] rd_wb,
   input  logic                  writeback_wb,
   input  logic [REG_ADDR_W-1:0] rd_pwb,
   input  logic                  valid_pwb,
   output cpu_pkg::bypass_sel_t  sel
);
   import cpu_pkg::*;

   always_comb begin
      sel = BYP_RF;
      // r0 reads as zero, so any in-flight write to it must never be bypassed
      if (ZERO_REG_EN && (rx_id == '0)) begin
         sel = BYP_RF;
      end else if (writeback_mem && (rd_mem == rx_id)) begin
         sel = BYP_MEM;
      end else if (writeback_wb && (rd_wb == rx_id)) begin
         sel = BYP_WB;
      end else if (valid_pwb && (rd_pwb == rx_id)) begin
         sel = BYP_PWB;
      end else begin
         sel = BYP_RF;
      end
   end

endmodule

// File: rtl/cpu_fw_unit.sv
// Operand forwarding unit: per-operand bypass selects plus the one-cycle-past-writeback tracker.
module cpu_fw_unit #(
   parameter int REG_ADDR_W  = cpu_pkg::REG_ADDR_W,
   parameter bit ZERO_REG_EN = 1'b1
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic [REG_ADDR_W-1:0] ra_id,
   input  logic [REG_ADDR_W-1:0] rb_id,
   input  logic [REG_ADDR_W-1:0] rd_mem,
   input  logic                  writeback_mem,
   input  logic [REG_ADDR_W-1:0] rd_wb,
   input  logic                  writeback_wb,
   output logic [1:0]            ra_bypass,
   output logic [1:0]            rb_bypass
);
   import cpu_pkg::*;

   CPU_FWUnit_if #(.AW(REG_ADDR_W)) fw_if ();

   logic [REG_ADDR_W-1:0] rd_pwb_d, rd_pwb_q;
   logic                  valid_pwb_d, valid_pwb_q;

   assign fw_if.ra_id         = ra_id;
   assign fw_if.rb_id         = rb_id;
   assign fw_if.rd_mem        = rd_mem;
   assign fw_if.writeback_mem = writeback_mem;
   assign fw_if.rd_wb         = rd_wb;
   assign fw_if.writeback_wb  = writeback_wb;

   // The register file write lands at this edge; the holding register keeps the value one more cycle.
   always_comb begin
      rd_pwb_d    = fw_if.rd_wb;
      valid_pwb_d = fw_if.writeback_wb;
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         rd_pwb_q    <= '0;
         valid_pwb_q <= 1'b0;
      end else begin
         rd_pwb_q    <= rd_pwb_d;
         valid_pwb_q <= valid_pwb_d;
      end
   end

   cpu_fw_operand_sel #(
      .REG_ADDR_W (REG_ADDR_W),
      .ZERO_REG_EN(ZERO_REG_EN)
   ) u_sel_a (
      .rx_id        (fw_if.ra_id),
      .rd_mem       (fw_if.rd_mem),
      .writeback_mem(fw_if.writeback_mem),
      .rd_wb        (fw_if.rd_wb),
      .writeback_wb (fw_if.writeback_wb),
      .rd_pwb       (rd_pwb_q),
      .valid_pwb    (valid_pwb_q),
      .sel          (fw_if.ra_bypass)
   );

   cpu_fw_operand_sel #(
      .REG_ADDR_W (REG_ADDR_W),
      .ZERO_REG_EN(ZERO_REG_EN)
   ) u_sel_b (
      .rx_id        (fw_if.rb_id),
      .rd_mem       (fw_if.rd_mem),
      .writeback_mem(fw_if.writeback_mem),
      .rd_wb        (fw_if.rd_wb),
      .writeback_wb (fw_if.writeback_wb),
      .rd_pwb       (rd_pwb_q),
      .valid_pwb    (valid_pwb_q),
      .sel          (fw_if.rb_bypass)
   );

   assign ra_bypass = fw_if.ra_bypass;
   assign rb_bypass = fw_if.rb_bypass;

endmodule

// File: tb/tb_cpu_fw_unit.sv
// Self-checking bench for cpu_fw_unit: directed cases then randomized traffic against a producer-history model.
module tb_cpu_fw_unit;

   logic       clock;
   logic       reset;
   logic [4:0] ra_id, rb_id, rd_mem, rd_wb;
   logic       writeback_mem, writeback_wb;
   logic [1:0] ra_bypass, rb_bypass;

   int n_checks = 0;
   int n_fail   = 0;

   // Model state: the write committed at the previous edge (if any).
   logic [4:0] m_prev_rd;
   logic       m_prev_vld;

   cpu_fw_unit #(
      .REG_ADDR_W (5),
      .ZERO_REG_EN(1'b1)
   ) dut (
      .clock        (clock),
      .reset        (reset),
      .ra_id        (ra_id),
      .rb_id        (rb_id),
      .rd_mem       (rd_mem),
      .writeback_mem(writeback_mem),
      .rd_wb        (rd_wb),
      .writeback_wb (writeback_wb),
      .ra_bypass    (ra_bypass),
      .rb_bypass    (rb_bypass)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic check_eq(input string tag, input logic [1:0] obs, input logic [1:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %b expected %b", tag, obs, exp);
      end
   endtask

   // Producers listed youngest first; the first live one naming the register supplies the operand.
   function automatic logic [1:0] model_sel(input logic [4:0] x);
      logic [4:0] prod_rd  [3];
      logic       prod_vld [3];
      logic [1:0] prod_src [3];
      prod_rd[0] = rd_mem;    prod_vld[0] = writeback_mem; prod_src[0] = 2'd1;
      prod_rd[1] = rd_wb;     prod_vld[1] = writeback_wb;  prod_src[1] = 2'd2;
      prod_rd[2] = m_prev_rd; prod_vld[2] = m_prev_vld;    prod_src[2] = 2'd3;
      if (x == 5'd0) return 2'd0;
      for (int i = 0; i < 3; i++)
         if (prod_vld[i] && prod_rd[i] == x) return prod_src[i];
      return 2'd0;
   endfunction

   task automatic drive(input logic [4:0] a, input logic [4:0] b,
                        input logic [4:0] rm, input logic wm,
                        input logic [4:0] rw, input logic ww, input logic rst);
      ra_id = a; rb_id = b; rd_mem = rm; writeback_mem = wm;
      rd_wb = rw; writeback_wb = ww; reset = rst;
      #1;
   endtask

   task automatic tick();
      @(posedge clock);
      if (reset) begin
         m_prev_rd  = 5'd0;
         m_prev_vld = 1'b0;
      end else begin
         m_prev_rd  = rd_wb;
         m_prev_vld = writeback_wb;
      end
      #1;
   endtask

   initial begin
      m_prev_rd = 5'd0; m_prev_vld = 1'b0;
      drive(5'd0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1);
      tick(); tick();

      drive(5'd5, 5'd7, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
      check_eq("reset_idle_a", ra_bypass, 2'b00);
      check_eq("reset_idle_b", rb_bypass, 2'b00);
      tick();

      drive(5'd5, 5'd6, 5'd0, 1'b0, 5'd5, 1'b1, 1'b0);
      check_eq("wb_hit_a", ra_bypass, 2'b10);
      check_eq("wb_miss_b", rb_bypass, 2'b00);
      tick();

      drive(5'd3, 5'd3, 5'd3, 1'b1, 5'd3, 1'b1, 1'b0);
      check_eq("mem_prio_a", ra_bypass, 2'b01);
      check_eq("mem_prio_b", rb_bypass, 2'b01);
      tick();

      drive(5'd1, 5'd2, 5'd0, 1'b0, 5'd9, 1'b1, 1'b0);
      tick();
      drive(5'd9, 5'd9, 5'd0, 1'b0, 5'd9, 1'b0, 1'b0);
      check_eq("pwb_hit_a", ra_bypass, 2'b11);
      check_eq("pwb_hit_b", rb_bypass, 2'b11);
      // Reset must win over a concurrent capture of a live write
      drive(5'd9, 5'd9, 5'd0, 1'b0, 5'd9, 1'b1, 1'b1);
      tick();
      drive(5'd9, 5'd9, 5'd0, 1'b0, 5'd9, 1'b0, 1'b0);
      check_eq("pwb_after_reset", ra_bypass, 2'b00);
      tick();

      drive(5'd0, 5'd4, 5'd0, 1'b1, 5'd0, 1'b1, 1'b0);
      check_eq("zero_reg_a", ra_bypass, 2'b00);
      tick();
      drive(5'd0, 5'd4, 5'd4, 1'b0, 5'd0, 1'b0, 1'b0);
      check_eq("zero_reg_pwb", ra_bypass, 2'b00);
      check_eq("mem_disabled_b", rb_bypass, 2'b00);
      tick();

      drive(5'd8, 5'd2, 5'd2, 1'b1, 5'd8, 1'b1, 1'b0);
      check_eq("indep_a", ra_bypass, 2'b10);
      check_eq("indep_b", rb_bypass, 2'b01);
      tick();

      for (int cyc = 0; cyc < 1000; cyc++) begin
         logic rst_now;
         rst_now = (cyc == 500) || (cyc == 501) || ($urandom_range(0, 63) == 0);
         drive(5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
               5'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
               5'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), rst_now);
         check_eq("rand_a", ra_bypass, model_sel(ra_id));
         check_eq("rand_b", rb_bypass, model_sel(rb_id));
         tick();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
